// File: rtl/usb_crc_engine.sv
// usb_crc_engine
// Serial CRC engine shared by the USB token (CRC5) and data (CRC16) paths.
// Accumulates qualified wire-order bits into an LFSR, reports the residual
// match for RX checking, and for TX shifts out the inverted CRC field
// MSB-first while feeding each emitted bit back into the LFSR. Because of
// that feedback, crc_ok rises on its own once a TX append completes.

module usb_crc_engine #(
    parameter int          CRC_W    = 16,
    parameter logic [15:0] POLY     = 16'h8005,
    parameter logic [15:0] INIT     = 16'hFFFF,
    parameter logic [15:0] RESIDUAL = 16'h800D
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             append_req,
    input  logic             shift_en,
    output logic             tx_bit,
    output logic             tx_busy,
    output logic             append_done,
    output logic [CRC_W-1:0] crc_value,
    output logic             crc_ok
);

    // Only the CRC5 and CRC16 flavours exist on the bus; anything else is a
    // wiring mistake that should stop elaboration.
    generate
        if (!(CRC_W == 5 || CRC_W == 16)) begin : g_bad_width
            $error("usb_crc_engine: CRC_W must be 5 or 16");
        end
        if ((POLY >> CRC_W) != 16'd0) begin : g_bad_poly
            $error("usb_crc_engine: POLY wider than CRC_W");
        end
        if ((RESIDUAL >> CRC_W) != 16'd0) begin : g_bad_residual
            $error("usb_crc_engine: RESIDUAL wider than CRC_W");
        end
    endgenerate

    localparam int                  CNT_W   = $clog2(CRC_W);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CRC_W - 1);
    localparam logic [CRC_W-1:0]    POLY_W  = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0]    INIT_W  = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0]    RES_W   = RESIDUAL[CRC_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CRC_W-1:0]   lfsr_reg;
    logic [CRC_W-1:0]   shifter_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               append_done_reg;

    // One LFSR step for a single accepted bit (MSB-first Galois form).
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic b);
        logic fb;
        fb       = b ^ cur[CRC_W-1];
        crc_step = {cur[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: clear wins, then append_req, then bit_valid.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ACCUM: begin
                    if (append_req) begin
                        state_next = ST_APPEND;
                    end else if (bit_valid) begin
                        state_next = ST_ACCUM;
                    end
                end
                ST_APPEND: begin
                    if (shift_en && (count_reg == '0)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // LFSR, append shifter, bit counter and the done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr_reg        <= '0;
            shifter_reg     <= '0;
            count_reg       <= '0;
            append_done_reg <= 1'b0;
        end else begin
            append_done_reg <= 1'b0;
            if (clear) begin
                lfsr_reg    <= INIT_W;
                shifter_reg <= '0;
                count_reg   <= '0;
            end else if (state_reg == ST_APPEND) begin
                // Emitted bits re-enter the LFSR so the residual self-checks.
                if (shift_en) begin
                    lfsr_reg    <= crc_step(lfsr_reg, shifter_reg[CRC_W-1]);
                    shifter_reg <= {shifter_reg[CRC_W-2:0], 1'b0};
                    if (count_reg == '0) begin
                        append_done_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end else if (append_req) begin
                // Any bit_valid presented this same cycle is deliberately dropped.
                shifter_reg <= ~lfsr_reg;
                count_reg   <= CNT_MAX;
            end else if (bit_valid) begin
                lfsr_reg <= crc_step(lfsr_reg, bit_in);
            end
        end
    end

    // Outputs decoded from the state and datapath registers.
    always_comb begin
        tx_busy = (state_reg == ST_APPEND);
        tx_bit  = tx_busy & shifter_reg[CRC_W-1];
    end

    assign append_done = append_done_reg;
    assign crc_value   = ~lfsr_reg;
    assign crc_ok      = (lfsr_reg == RES_W);

endmodule

// File: tb/tb_usb_crc_engine.sv
// tb_usb_crc_engine
// Directed checks of a CRC16 and a CRC5 instance driven by shared inputs.
// Expected values are hand-computed constants; one line per comparison.

module tb_usb_crc_engine;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        bit_valid;
    logic        bit_in;
    logic        append_req;
    logic        shift_en;

    logic        tx_bit16, tx_busy16, append_done16, crc_ok16;
    logic [15:0] crc_value16;
    logic        tx_bit5, tx_busy5, append_done5, crc_ok5;
    logic [4:0]  crc_value5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_crc_engine #(
        .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUAL(16'h800D)
    ) u_crc16 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .bit_valid(bit_valid),
        .bit_in(bit_in), .append_req(append_req), .shift_en(shift_en),
        .tx_bit(tx_bit16), .tx_busy(tx_busy16), .append_done(append_done16),
        .crc_value(crc_value16), .crc_ok(crc_ok16)
    );

    usb_crc_engine #(
        .CRC_W(5), .POLY(16'h0005), .INIT(16'hFFFF), .RESIDUAL(16'h000C)
    ) u_crc5 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .bit_valid(bit_valid),
        .bit_in(bit_in), .append_req(append_req), .shift_en(shift_en),
        .tx_bit(tx_bit5), .tx_busy(tx_busy5), .append_done(append_done5),
        .crc_value(crc_value5), .crc_ok(crc_ok5)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Send the n low bits of v, LSB first (USB wire order for a field).
    task automatic send_lsb(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    // Send the n low bits of v, MSB first (CRC field order).
    task automatic send_msb(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_append();
        append_req = 1'b1;
        tick();
        append_req = 1'b0;
    endtask

    task automatic strobe();
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
    endtask

    initial begin
        logic [15:0] exp16;
        logic [10:0] token;

        n_rst = 1'b0; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        append_req = 1'b0; shift_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_crc16", crc_value16, 16'hFFFF);
        check("rst_crc5", {11'd0, crc_value5}, 16'h001F);
        check("rst_ok16", {15'd0, crc_ok16}, 16'd0);
        check("rst_busy", {15'd0, tx_busy16}, 16'd0);
        check("rst_txbit", {15'd0, tx_bit16}, 16'd0);
        check("rst_done", {15'd0, append_done16}, 16'd0);
        #2 n_rst = 1'b1;
        tick();

        // CRC16 empty data packet: field is all zeros
        do_clear();
        check("empty_crc", crc_value16, 16'h0000);
        pulse_append();
        check("empty_busy", {15'd0, tx_busy16}, 16'd1);
        for (int i = 0; i < 16; i++) begin
            check("empty_txbit", {15'd0, tx_bit16}, 16'd0);
            check("empty_nodone", {15'd0, append_done16}, 16'd0);
            strobe();
        end
        check("empty_done", {15'd0, append_done16}, 16'd1);
        check("empty_idle", {15'd0, tx_busy16}, 16'd0);
        tick();
        check("empty_ok", {15'd0, crc_ok16}, 16'd1);
        check("empty_pulse", {15'd0, append_done16}, 16'd0);

        // CRC5 token addr=0x15 endp=0xE -> 5'b10111
        do_clear();
        send_lsb(16'h0015, 7);
        send_lsb(16'h000E, 4);
        check("tok1_crc", {11'd0, crc_value5}, 16'h0017);
        send_msb(16'h0017, 5);
        check("tok1_ok", {15'd0, crc_ok5}, 16'd1);

        // CRC5 token addr=0x3A endp=0xA -> 5'b11100
        do_clear();
        send_lsb(16'h003A, 7);
        send_lsb(16'h000A, 4);
        check("tok2_crc", {11'd0, crc_value5}, 16'h001C);
        send_msb(16'h001C, 5);
        check("tok2_ok", {15'd0, crc_ok5}, 16'd1);

        // Any single flipped data bit must break the residual
        token = {4'hA, 7'h3A};
        for (int k = 0; k < 11; k++) begin
            do_clear();
            send_lsb({5'd0, token ^ (11'd1 << k)}, 11);
            send_msb(16'h001C, 5);
            check("tok2_flip", {15'd0, crc_ok5}, 16'd0);
        end

        // CRC16 of byte 0x01 -> 16'h81FE, appended with strobes every 3rd cycle
        do_clear();
        send_lsb(16'h0001, 8);
        check("gap_crc", crc_value16, 16'h81FE);
        exp16 = 16'h81FE;
        pulse_append();
        for (int i = 15; i >= 0; i--) begin
            check("gap_txbit", {15'd0, tx_bit16}, {15'd0, exp16[i]});
            for (int g = 0; g < 2; g++) begin
                tick();
                check("gap_hold", {15'd0, tx_bit16}, {15'd0, exp16[i]});
                check("gap_busy", {15'd0, tx_busy16}, 16'd1);
            end
            strobe();
        end
        check("gap_idle", {15'd0, tx_busy16}, 16'd0);
        check("gap_done", {15'd0, append_done16}, 16'd1);
        tick();
        check("gap_ok", {15'd0, crc_ok16}, 16'd1);

        // clear after the 7th strobe aborts the append
        do_clear();
        pulse_append();
        repeat (7) strobe();
        check("abort_busy_pre", {15'd0, tx_busy16}, 16'd1);
        do_clear();
        check("abort_busy", {15'd0, tx_busy16}, 16'd0);
        check("abort_done", {15'd0, append_done16}, 16'd0);
        check("abort_crc", crc_value16, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            strobe();
            check("abort_nodone", {15'd0, append_done16}, 16'd0);
        end

        // shift_en outside an append is ignored
        do_clear();
        strobe();
        check("idle_shift_crc", crc_value16, 16'h0000);
        check("idle_shift_busy", {15'd0, tx_busy16}, 16'd0);

        // append_req with bit_valid on the same edge drops the bit
        append_req = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        append_req = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check("prio_crc", crc_value16, 16'h0000);
        check("prio_busy", {15'd0, tx_busy16}, 16'd1);
        send_bit(1'b1);
        check("append_ignore_bit", crc_value16, 16'h0000);

        // Asynchronous reset between edges during an append
        do_clear();
        send_lsb(16'h0001, 8);
        pulse_append();
        repeat (3) strobe();
        #2 n_rst = 1'b0;
        #1;
        check("arst_crc", crc_value16, 16'hFFFF);
        check("arst_busy", {15'd0, tx_busy16}, 16'd0);
        check("arst_ok", {15'd0, crc_ok16}, 16'd0);
        check("arst_txbit", {15'd0, tx_bit16}, 16'd0);
        #3 n_rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
